// File: rtl/intersection_pkg.sv
// intersection_pkg: shared state and lamp encodings for the intersection controller.
package intersection_pkg;
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_t;
    // Lamp order is {red,yellow,green}
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    function automatic logic [2:0] ns_lamp(state_t s);
        return s == NS_GREEN ? GREEN : s == NS_YELLOW ? YELLOW : RED;
    endfunction
    function automatic logic [2:0] ew_lamp(state_t s);
        return s == EW_GREEN ? GREEN : s == EW_YELLOW ? YELLOW : RED;
    endfunction
endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// phase_timer: 8-bit phase counter with clear, enable and saturation at 255.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] q,
    output logic [7:0] q_nx
);
    // q_nx is exported so the owner can register outputs that depend on the next count
    assign q_nx = clr ? 8'd0 : (en && q != 8'hff) ? q + 8'd1 : q;
    always_ff @(posedge clk) begin
        if (rst) q <= 8'd0;
        else     q <= q_nx;
    end
endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: main-road/side-road traffic light controller with pedestrian walk phase.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ew_car,
    input  logic       ped_btn,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] state_out
);
    localparam logic [7:0] GMIN_L = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_L = 8'(GREEN_MAX - 1);
    localparam logic [7:0] YEL_L  = 8'(YELLOW_T - 1);
    localparam logic [7:0] AR_L   = 8'(ALLRED_T - 1);
    localparam logic [7:0] WALK_L = 8'(WALK_T - 1);
    localparam logic [7:0] WALK_N = 8'(WALK_T);
    state_t     state, state_nx;
    logic [7:0] timer, timer_nx;
    logic       ped_pend, ped_pend_nx, walk_act, walk_act_nx, entry;
    phase_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (state_nx != state),
        .q    (timer),
        .q_nx (timer_nx)
    );
    always_comb begin
        state_nx = state;
        if (en) begin
            case (state)
                NS_GREEN:  state_nx = (timer >= GMIN_L && (ew_car || ped_pend)) ? NS_YELLOW : NS_GREEN;
                NS_YELLOW: state_nx = timer == YEL_L ? ALLRED_A : NS_YELLOW;
                ALLRED_A:  state_nx = timer == AR_L ? EW_GREEN : ALLRED_A;
                EW_GREEN:  state_nx = (timer >= GMIN_L && (!ew_car || timer == GMAX_L)) ? EW_YELLOW : EW_GREEN;
                EW_YELLOW: state_nx = timer == YEL_L ? ALLRED_B : EW_YELLOW;
                ALLRED_B:  state_nx = timer == AR_L ? NS_GREEN : ALLRED_B;
                default:   state_nx = ALLRED_B;
            endcase
        end
    end
    // A press on the EW_GREEN entry cycle survives the clear and is served next time round
    always_comb begin
        entry       = en && state_nx == EW_GREEN && state != EW_GREEN;
        ped_pend_nx = ped_btn || (ped_pend && !entry);
        walk_act_nx = entry ? ped_pend
                    : (en && state == EW_GREEN && timer == WALK_L) ? 1'b0 : walk_act;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ALLRED_B;
            ped_pend <= 1'b0;
            walk_act <= 1'b0;
            ns_light <= RED;
            ew_light <= RED;
            walk     <= 1'b0;
        end else begin
            state    <= state_nx;
            ped_pend <= ped_pend_nx;
            walk_act <= walk_act_nx;
            ns_light <= ns_lamp(state_nx);
            ew_light <= ew_lamp(state_nx);
            walk     <= state_nx == EW_GREEN && walk_act_nx && timer_nx < WALK_N;
        end
    end
    assign state_out = state;
endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed vector table plus hand sequences for the intersection controller.
module tb_intersection_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, ew_car = 1'b0, ped_btn = 1'b0;
    logic [2:0] ns_light, ew_light, state_out;
    logic       walk;
    int         checks = 0, errors = 0;

    intersection_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ew_car    (ew_car),
        .ped_btn   (ped_btn),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .walk      (walk),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, e, c, p;
        logic [2:0] st;
        logic       w;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [2:0] exp_ns(logic [2:0] s);
        return s == 3'd0 ? 3'b001 : s == 3'd1 ? 3'b010 : 3'b100;
    endfunction
    function automatic logic [2:0] exp_ew(logic [2:0] s);
        return s == 3'd3 ? 3'b001 : s == 3'd4 ? 3'b010 : 3'b100;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, e, c, p, input logic [2:0] st, input logic w, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{r, e, c, p, st, w});
    endtask

    task automatic step(input logic r, e, c, p);
        rst = r; en = e; ew_car = c; ped_btn = p;
        @(posedge clk);
        #1;
        checks++;
        if (ns_light != 3'b100 && ew_light != 3'b100) begin
            errors++;
            $display("FAIL conflict: ns=%b ew=%b", ns_light, ew_light);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] st, input logic w);
        check({name, " state"}, int'(state_out), int'(st));
        check({name, " ns"}, int'(ns_light), int'(exp_ns(st)));
        check({name, " ew"}, int'(ew_light), int'(exp_ew(st)));
        check({name, " walk"}, int'(walk), int'(w));
    endtask

    initial begin
        int ns_len, ew_len, walk_in, walk_out, visits, w1, w2;
        logic [2:0] prev;
        logic seen_nonns, reached;
        // Car held from NS_GREEN cycle 0: 4 / 2 / 1 / 8 / 2 / 1
        add(1, 0, 1, 0, 3'd5, 0, 1);
        add(0, 1, 1, 0, 3'd0, 0, 4);
        add(0, 1, 1, 0, 3'd1, 0, 2);
        add(0, 1, 1, 0, 3'd2, 0, 1);
        add(0, 1, 1, 0, 3'd3, 0, 8);
        add(0, 1, 1, 0, 3'd4, 0, 2);
        add(0, 1, 1, 0, 3'd5, 0, 1);
        add(0, 1, 1, 0, 3'd0, 0, 1);
        // Reset beats en, then no demand holds NS_GREEN
        add(1, 1, 0, 0, 3'd5, 0, 1);
        add(0, 1, 0, 0, 3'd0, 0, 22);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].p);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].w);
        end

        // Single ped pulse, no cars
        step(1, 1, 0, 0);
        ns_len = 0; ew_len = 0; walk_in = 0; walk_out = 0; seen_nonns = 0;
        for (int i = 0; i < 35; i++) begin
            step(0, 1, 0, i == 1);
            if (state_out != 3'd0) seen_nonns = 1;
            if (state_out == 3'd0 && !seen_nonns) ns_len++;
            if (state_out == 3'd3) ew_len++;
            if (walk && state_out == 3'd3) walk_in++;
            if (walk && state_out != 3'd3) walk_out++;
        end
        check("ped ns_green_len", ns_len, 4);
        check("ped ew_green_len", ew_len, 4);
        check("ped walk_len", walk_in, 3);
        check("ped walk_outside", walk_out, 0);
        check("ped final state", int'(state_out), 0);

        // Pause mid NS_YELLOW
        step(1, 1, 0, 0);
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step(0, 1, 1, 0);
            reached = state_out == 3'd1;
        end
        check("pause reach yellow", int'(reached), 1);
        step(0, 1, 1, 0);
        check_all("pause yel t1", 3'd1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            check_all($sformatf("pause hold%0d", i), 3'd1, 0);
        end
        step(0, 1, 1, 0);
        check_all("pause resume", 3'd2, 0);

        // Reset during walk
        step(1, 1, 0, 0);
        reached = 0;
        for (int i = 0; i < 30 && !reached; i++) begin
            step(0, 1, 0, i == 1);
            reached = state_out == 3'd3;
        end
        check("rstwalk reach ew", int'(reached), 1);
        check("rstwalk walk on", int'(walk), 1);
        step(1, 1, 0, 0);
        check_all("rstwalk after", 3'd5, 0);

        // Press on EW_GREEN entry cycle yields a second walk
        step(1, 1, 0, 0);
        visits = 0; w1 = 0; w2 = 0; prev = 3'd5;
        for (int i = 0; i < 80; i++) begin
            step(0, 1, 0, i == 1 || (state_out == 3'd2 && visits == 0));
            if (state_out == 3'd3 && prev != 3'd3) visits++;
            if (walk && visits == 1) w1++;
            if (walk && visits == 2) w2++;
            prev = state_out;
        end
        check("reped visits", visits, 2);
        check("reped walk1", w1, 3);
        check("reped walk2", w2, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter GREEN_MIN, default 4, minimum green cycles for either road.
REQ-002 SHALL have parameter GREEN_MAX, default 8, maximum east-west (EW) green cycles under continuous demand.
REQ-003 SHALL have parameter YELLOW_T, default 2, yellow duration in cycles.
REQ-004 SHALL have parameter ALLRED_T, default 1, all-red clearance duration in cycles.
REQ-005 SHALL have parameter WALK_T, default 3, walk duration in cycles; constraint 1 <= WALK_T <= GREEN_MIN <= GREEN_MAX <= 255.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port en  input  1  run enable; low pauses the controller.
REQ-009 SHALL have port ew_car  input  1  side-road (EW) vehicle sensor, level.
REQ-010 SHALL have port ped_btn  input  1  pedestrian request to cross the north-south (NS) road, pulse or level.
REQ-011 SHALL have port ns_light  output  3  NS lamps {red,yellow,green}, one-hot.
REQ-012 SHALL have port ew_light  output  3  EW lamps {red,yellow,green}, one-hot.
REQ-013 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-014 SHALL have port state_out  output  3  current state encoding.

Function
REQ-015 SHALL implement states NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5; codes 6-7 SHALL go to ALLRED_B on the next enabled cycle.
REQ-016 SHALL keep a phase timer, 8 bits, that clears to 0 on every state change, increments each enabled cycle otherwise and saturates at 255.
REQ-017 SHALL stay in fixed states for exactly their duration in enabled cycles, exiting when timer == T-1: NS_YELLOW/EW_YELLOW use YELLOW_T; ALLRED_A/ALLRED_B use ALLRED_T.
REQ-018 SHALL follow transitions NS_YELLOW->ALLRED_A->EW_GREEN->EW_YELLOW->ALLRED_B->NS_GREEN.
REQ-019 SHALL leave NS_GREEN for NS_YELLOW when timer >= GREEN_MIN-1 and (ew_car or ped_pend); otherwise NS_GREEN SHALL hold indefinitely.
REQ-020 SHALL leave EW_GREEN for EW_YELLOW when timer >= GREEN_MIN-1 and (ew_car==0 or timer == GREEN_MAX-1).
REQ-021 SHALL set internal flag ped_pend on any cycle with ped_btn=1, independent of en.
REQ-022 SHALL copy ped_pend into walk_act and clear ped_pend on entry to EW_GREEN; a ped_btn press in that same cycle SHALL win, leaving ped_pend set.
REQ-023 SHALL assert walk in EW_GREEN while walk_act=1 and timer < WALK_T, then clear walk_act.
REQ-024 SHALL decode lights from state only: NS green in NS_GREEN, NS yellow in NS_YELLOW, NS red otherwise; EW green in EW_GREEN, EW yellow in EW_YELLOW, EW red otherwise.
REQ-025 SHALL never show non-red lamps on both roads in the same cycle.
REQ-026 SHALL hold state, timer and walk_act while en=0; outputs SHALL remain those of the held state.
REQ-027 SHALL register all outputs, with state_out equal to the state register.

Reset
REQ-028 SHALL give rst priority over en and all other inputs.
REQ-029 SHALL on reset set state=ALLRED_B, timer=0, ped_pend=0 and walk_act=0, giving ns_light=100, ew_light=100, walk=0 and state_out=5.
REQ-030 SHALL abandon any phase when rst is asserted mid-phase, with no yellow step.

Structure
REQ-031 SHALL place state encodings and lamp encodings (RED=100, YELLOW=010, GREEN=001) in shared package intersection_pkg.
REQ-032 SHALL use one sub-module, phase_timer: an 8-bit counter with clear, enable and saturation.

Verification
REQ-033 SHALL cover reset then en=1 with no demand, defaults: state_out 5 for 1 cycle, then 0, held for at least 20 cycles; ns_light=001 and ew_light=100.
REQ-034 SHALL cover ew_car=1 from cycle 0 of NS_GREEN: NS_GREEN 4 cycles, NS_YELLOW 2, ALLRED_A 1, then EW_GREEN 8 cycles because car is held, EW_YELLOW 2, ALLRED_B 1.
REQ-035 SHALL cover a 1-cycle ped_btn pulse with ew_car=0: NS_GREEN exits after GREEN_MIN; in EW_GREEN walk=1 for exactly 3 cycles; EW_GREEN lasts 4 cycles; walk=0 after.
REQ-036 SHALL cover en dropped for 5 cycles mid NS_YELLOW: state and lights frozen, and NS_YELLOW totals exactly 2 enabled cycles.
REQ-037 SHALL cover rst asserted during EW_GREEN with walk=1: next cycle state_out=5, walk=0, both lights 100.
REQ-038 SHALL cover ped_btn pressed on the EW_GREEN entry cycle: a second walk is served in the following EW_GREEN; every cycle is checked for no conflicting non-red lamps.
